ghash_controller: RTL and testbench
===================================

GHASH_CONTROLLER -- requirements
Module: ghash_controller

Interface
REQ-001 Parameter: none; block width fixed at 128 bits via package type gf128_block_t.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 key_valid  input  1  hash key H offered.
REQ-005 key_data  input  128  hash key H.
REQ-006 key_ready  output  1  key accepted this cycle when key_valid & key_ready.
REQ-007 s_valid  input  1  data block offered.
REQ-008 s_data  input  128  data block X_i (already padded).
REQ-009 s_last  input  1  marks final block of a message.
REQ-010 s_ready  output  1  block accepted when s_valid & s_ready.
REQ-011 m_valid  output  1  tag available.
REQ-012 m_tag  output  128  GHASH result Y_n.
REQ-013 m_ready  input  1  tag consumed when m_valid & m_ready.
REQ-014 busy  output  1  high in any state other than IDLE with no message open.

Function
REQ-015 The block SHALL compute Y_i = (Y_{i-1} XOR X_i) * H in GF(2^128) with the GCM polynomial, Y_0 = 0, and one gf128_multiplier instance shared across all blocks.
REQ-016 States: IDLE, ACCEPT, MUL, DONE.
REQ-017 IDLE: key_ready=1; s_ready=1 only when key_loaded=1 and key_valid=0; key_valid has priority over s_valid in the same cycle.
REQ-018 Key handshake SHALL load H register and set key_loaded in one cycle; state stays IDLE.
REQ-019 Block handshake in IDLE or ACCEPT SHALL register operand A = acc XOR s_data, capture s_last, and go to MUL next cycle.
REQ-020 MUL: s_ready=0, key_ready=0; acc <= A*H (registered); next state DONE if captured last else ACCEPT.
REQ-021 ACCEPT: s_ready=1, key_ready=0; key_valid ignored mid-message.
REQ-022 Throughput: one block per 2 cycles; a tag SHALL assert m_valid exactly 2 cycles after the last-block handshake.
REQ-023 DONE: m_valid=1, m_tag=acc held stable until m_ready; on handshake acc <= 0, state IDLE, same cycle m_valid drops next edge.
REQ-024 s_valid with key_loaded=0 SHALL stall (s_ready=0), no error.
REQ-025 m_tag SHALL read as zero whenever m_valid=0.
REQ-026 s_last on the first block SHALL yield a single-block tag X_1*H.

Reset
REQ-027 rst SHALL force state IDLE, acc=0, operand=0, key_loaded=0, H=0 in the next cycle, from any state including MUL or DONE.
REQ-028 Reset outputs: key_ready=1, s_ready=0, m_valid=0, m_tag=0, busy=0.
REQ-029 A message interrupted by rst SHALL be discarded with no tag emitted.

Structure
REQ-030 Shared package gf128_pkg SHALL hold gf128_block_t, GF128_ZERO constant and the ghash state enum.
REQ-031 One sub-module: gf128_multiplier (x, y, z), combinational, inputs driven from operand and H registers.
REQ-032 Controller logic SHALL be a single FSM plus datapath registers; no other sub-modules.

Verification
REQ-033 Single block: H=66e94bd4ef8a2c3b884cfa59ca342b2e, X1=0388dace60b6a392f328c2b971b2fe78 with s_last -> m_tag=5e2ec746917062882c85b0685353deb7, m_valid 2 cycles after handshake.
REQ-034 Two blocks: same H, X1 as above, X2=00000000000000000000000000000080 last -> m_tag=f38cbb1ad69223dcc3457ae5b6b0f885.
REQ-035 Back-pressure: hold m_ready=0 for 10 cycles in DONE -> m_tag stable, s_ready=0, then accept; next message starts from acc=0 and reproduces REQ-033 tag.
REQ-036 Priority/stall: key_valid and s_valid both high in IDLE -> key accepted, block accepted next cycle; s_valid before any key -> s_ready stays 0.
REQ-037 Reset mid-operation: assert rst during MUL of block 1 of a 2-block message -> no m_valid, all outputs at reset values; key reload then REQ-033 passes.
REQ-038 Key change in ACCEPT ignored: key_valid with new H mid-message -> key_ready=0, tag equals REQ-034 value.

Source files
------------

// File: rtl/gf128_pkg.sv
// Shared types for the GHASH controller: 128-bit GF(2^128) block, the zero
// block, the GCM reduction constant and the controller state encoding.
package gf128_pkg;

  typedef logic [127:0] gf128_block_t;

  localparam gf128_block_t GF128_ZERO = '0;

  // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM's reflected bit order
  localparam gf128_block_t GF128_R = {8'he1, 120'h0};

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    MUL,
    DONE
  } ghash_state_t;

endpackage

// File: rtl/ghash_controller_if.sv
// Handshake bundle for the GHASH controller: key load, block stream, tag stream
// and the busy flag. The master side drives keys/blocks and consumes tags.
interface ghash_controller_if;
  import gf128_pkg::*;

  logic         key_valid;
  gf128_block_t key_data;
  logic         key_ready;

  logic         s_valid;
  gf128_block_t s_data;
  logic         s_last;
  logic         s_ready;

  logic         m_valid;
  gf128_block_t m_tag;
  logic         m_ready;

  logic         busy;

  modport master (
    output key_valid, key_data, s_valid, s_data, s_last, m_ready,
    input  key_ready, s_ready, m_valid, m_tag, busy
  );

  modport slave (
    input  key_valid, key_data, s_valid, s_data, s_last, m_ready,
    output key_ready, s_ready, m_valid, m_tag, busy
  );

endinterface

// File: rtl/gf128_multiplier.sv
// Combinational GF(2^128) multiplier in GCM bit order (bit 127 is the x^0
// coefficient), using the shift-and-reduce method over all 128 bits of x.
module gf128_multiplier
  import gf128_pkg::*;
(
  input  gf128_block_t x,
  input  gf128_block_t y,
  output gf128_block_t z
);

  // Walk x from its x^0 coefficient upward while V tracks y * x^i mod P
  function automatic gf128_block_t gf_mul(input gf128_block_t a, input gf128_block_t b);
    gf128_block_t prod;
    gf128_block_t v;
    prod = GF128_ZERO;
    v    = b;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) begin
        prod = prod ^ v;
      end
      if (v[0]) begin
        v = (v >> 1) ^ GF128_R;
      end else begin
        v = v >> 1;
      end
    end
    return prod;
  endfunction

  assign z = gf_mul(x, y);

endmodule

// File: rtl/ghash_controller.sv
// GHASH controller: accumulates Y_i = (Y_{i-1} ^ X_i) * H over a message using
// a single shared multiplier, then presents the tag until it is consumed.
module ghash_controller
  import gf128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ghash_controller_if.slave  bus
);

  ghash_state_t state;
  ghash_state_t state_next;

  gf128_block_t h_reg;
  gf128_block_t acc;
  gf128_block_t operand;
  gf128_block_t product;
  logic         last_q;
  logic         key_loaded;

  logic key_ready;
  logic s_ready;
  logic m_valid;
  logic busy;
  logic key_fire;
  logic blk_fire;

  // The multiplier always sees the registered operand and key, so MUL is one full cycle
  gf128_multiplier u_mul (
    .x (operand),
    .y (h_reg),
    .z (product)
  );

  // Keys are only taken in IDLE and win over a block offered in the same cycle
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        key_ready = 1'b1;
        s_ready   = key_loaded & ~bus.key_valid;
        if (key_loaded && !bus.key_valid && bus.s_valid) begin
          state_next = MUL;
        end
      end
      ACCEPT: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          state_next = MUL;
        end
      end
      MUL: begin
        state_next = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign key_fire = bus.key_valid & key_ready;
  assign blk_fire = bus.s_valid & s_ready;

  // Datapath registers; the accumulator clears as the tag is handed off
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      h_reg      <= GF128_ZERO;
      acc        <= GF128_ZERO;
      operand    <= GF128_ZERO;
      last_q     <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      state <= state_next;
      if (key_fire) begin
        h_reg      <= bus.key_data;
        key_loaded <= 1'b1;
      end
      if (blk_fire) begin
        operand <= acc ^ bus.s_data;
        last_q  <= bus.s_last;
      end
      if (state == MUL) begin
        acc <= product;
      end else if (state == DONE && bus.m_ready) begin
        acc <= GF128_ZERO;
      end
    end
  end

  assign bus.key_ready = key_ready;
  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = m_valid;
  assign bus.m_tag     = m_valid ? acc : GF128_ZERO;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_ghash_controller.sv
// Directed and randomized checks of ghash_controller against a polynomial
// reference model (bit-reverse, carry-less multiply, reduce, bit-reverse).
module tb_ghash_controller;
  import gf128_pkg::*;

  localparam gf128_block_t H_VEC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam gf128_block_t X1    = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam gf128_block_t X2    = 128'h00000000000000000000000000000080;
  localparam gf128_block_t TAG1  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam gf128_block_t TAG2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic clk = 1'b0;
  logic rst;
  int   pass_count  = 0;
  int   check_count = 0;

  always #5 clk = ~clk;

  ghash_controller_if bus ();

  ghash_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic gf128_block_t reverse_bits(input gf128_block_t a);
    gf128_block_t r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Ordinary polynomial arithmetic: bit i of the reversed value is the x^i coefficient
  function automatic gf128_block_t ref_mul(input gf128_block_t a, input gf128_block_t b);
    logic [254:0] prod;
    logic [254:0] ar;
    logic [254:0] poly;
    gf128_block_t br;
    ar   = {127'b0, reverse_bits(a)};
    br   = reverse_bits(b);
    poly = (255'd1 << 128) | 255'h87;
    prod = '0;
    for (int i = 0; i < 128; i++) if (br[i]) prod = prod ^ (ar << i);
    for (int d = 254; d >= 128; d--) if (prod[d]) prod = prod ^ (poly << (d - 128));
    return reverse_bits(prod[127:0]);
  endfunction

  function automatic gf128_block_t ref_ghash(input gf128_block_t h, input gf128_block_t blocks[$]);
    gf128_block_t y;
    y = '0;
    foreach (blocks[i]) y = ref_mul(y ^ blocks[i], h);
    return y;
  endfunction

  function automatic gf128_block_t rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  task automatic checkReset(input string tag);
    checkBit({tag, " key_ready"}, bus.key_ready, 1'b1);
    checkBit({tag, " s_ready"}, bus.s_ready, 1'b0);
    checkBit({tag, " m_valid"}, bus.m_valid, 1'b0);
    checkOutput({tag, " m_tag"}, bus.m_tag, GF128_ZERO);
    checkBit({tag, " busy"}, bus.busy, 1'b0);
  endtask

  task automatic loadKey(input gf128_block_t h);
    bus.key_valid = 1'b1;
    bus.key_data  = h;
    settle();
    checkBit("key_ready idle", bus.key_ready, 1'b1);
    tick();
    bus.key_valid = 1'b0;
    bus.key_data  = rand_block();
  endtask

  task automatic releaseTag(input string tag);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    settle();
    checkBit({tag, " m_valid after take"}, bus.m_valid, 1'b0);
    checkOutput({tag, " m_tag after take"}, bus.m_tag, GF128_ZERO);
  endtask

  // Sends a whole message with random inter-block gaps, then checks latency,
  // tag value and tag stability under a fixed number of back-pressure cycles
  task automatic applyStimulus(input gf128_block_t h, input gf128_block_t blocks[$],
                               input int max_gap, input int stall, input string tag,
                               output gf128_block_t tag_seen);
    gf128_block_t exp;
    int waited;
    int lat;
    exp = ref_ghash(h, blocks);
    foreach (blocks[i]) begin
      repeat ($urandom_range(0, max_gap)) tick();
      bus.s_valid = 1'b1;
      bus.s_data  = blocks[i];
      bus.s_last  = (i == blocks.size() - 1);
      settle();
      waited = 0;
      while (!bus.s_ready && waited < 20) begin
        tick();
        settle();
        waited++;
      end
      checkBit({tag, " s_ready"}, bus.s_ready, 1'b1);
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = rand_block();
    end
    settle();
    checkBit({tag, " m_valid in MUL"}, bus.m_valid, 1'b0);
    lat = 1;
    while (!bus.m_valid && lat < 8) begin
      tick();
      settle();
      lat++;
    end
    checkOutput({tag, " latency"}, 128'(lat), 128'd2);
    checkOutput({tag, " m_tag"}, bus.m_tag, exp);
    tag_seen = bus.m_tag;
    repeat (stall) begin
      tick();
      settle();
      checkOutput({tag, " m_tag held"}, bus.m_tag, exp);
      checkBit({tag, " s_ready in DONE"}, bus.s_ready, 1'b0);
    end
    releaseTag(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    gf128_block_t q[$];
    gf128_block_t seen;
    gf128_block_t h_rand;

    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.m_ready   = 1'b0;
    tick();
    tick();
    settle();
    checkReset("reset");
    rst = 1'b0;
    tick();

    // Block offered before any key has been loaded must stall
    bus.s_valid = 1'b1;
    bus.s_data  = X1;
    bus.s_last  = 1'b1;
    repeat (3) begin
      settle();
      checkBit("no key s_ready", bus.s_ready, 1'b0);
      checkBit("no key busy", bus.busy, 1'b0);
      tick();
    end

    // Key and block together: key first, block on the following cycle
    bus.key_valid = 1'b1;
    bus.key_data  = H_VEC;
    settle();
    checkBit("prio key_ready", bus.key_ready, 1'b1);
    checkBit("prio s_ready", bus.s_ready, 1'b0);
    tick();
    bus.key_valid = 1'b0;
    settle();
    checkBit("prio s_ready next", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    settle();
    checkBit("single busy in MUL", bus.busy, 1'b1);
    checkBit("single m_valid in MUL", bus.m_valid, 1'b0);
    tick();
    settle();
    checkBit("single m_valid", bus.m_valid, 1'b1);
    checkOutput("single m_tag", bus.m_tag, TAG1);

    // Ten cycles of back-pressure on the tag
    repeat (10) begin
      tick();
      settle();
      checkOutput("backpressure m_tag", bus.m_tag, TAG1);
      checkBit("backpressure s_ready", bus.s_ready, 1'b0);
      checkBit("backpressure key_ready", bus.key_ready, 1'b0);
    end
    releaseTag("backpressure");
    checkBit("after tag busy", bus.busy, 1'b0);

    q.delete();
    q.push_back(X1);
    applyStimulus(H_VEC, q, 0, 0, "repeat single", seen);
    checkOutput("repeat single vector", seen, TAG1);

    // Key offered mid-message must be ignored
    bus.s_valid = 1'b1;
    bus.s_data  = X1;
    bus.s_last  = 1'b0;
    settle();
    checkBit("two block s_ready 1", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    tick();
    bus.key_valid = 1'b1;
    bus.key_data  = rand_block();
    settle();
    checkBit("accept key_ready", bus.key_ready, 1'b0);
    checkBit("accept busy", bus.busy, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = X2;
    bus.s_last  = 1'b1;
    settle();
    checkBit("two block s_ready 2", bus.s_ready, 1'b1);
    tick();
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.key_valid = 1'b0;
    tick();
    settle();
    checkBit("two block m_valid", bus.m_valid, 1'b1);
    checkOutput("two block m_tag", bus.m_tag, TAG2);
    releaseTag("two block");
    applyStimulus(H_VEC, q, 0, 0, "key kept", seen);

    // Reset while block 1 of a two-block message is in MUL
    bus.s_valid = 1'b1;
    bus.s_data  = X1;
    bus.s_last  = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    settle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checkReset("mid reset");
    bus.s_valid = 1'b1;
    bus.s_data  = X2;
    bus.s_last  = 1'b1;
    repeat (4) begin
      tick();
      settle();
      checkBit("post reset m_valid", bus.m_valid, 1'b0);
      checkBit("post reset s_ready", bus.s_ready, 1'b0);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    loadKey(H_VEC);
    applyStimulus(H_VEC, q, 0, 0, "reload single", seen);
    checkOutput("reload single vector", seen, TAG1);

    // Random keys, message lengths, gaps and back-pressure
    for (int n = 0; n < 12; n++) begin
      h_rand = rand_block();
      loadKey(h_rand);
      q.delete();
      repeat ($urandom_range(1, 4)) q.push_back(rand_block());
      applyStimulus(h_rand, q, 2, $urandom_range(0, 3), "random", seen);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
